title_screen_animator: RTL and testbench

- Pixel-pipelined title-screen compositor for the Pong Toss front end. Sits between the VGA timing generator and the RGB output mux.
- Overlays a bouncing ball above a target cup, a steady title, and a blinking "START GAME" prompt.
- On a start press, flashes the prompt at a faster rate for a fixed number of frames, then signals `screen_done` to the game FSM.
- Glyph hit flags for the title and prompt come from the shared glyph decoder. Geometry, colours and timing are parameters.

---
 rtl/title_screen_animator_if.sv | 25 ++
 rtl/title_screen_animator.sv | 231 +++++++++++++++++++++++
 tb/tb_title_screen_animator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/title_screen_animator_if.sv
// Pixel/control bundle between the video front end and the title-screen compositor.
interface title_screen_animator_if #(
   parameter int COLOR_W = 4
);
   logic [9:0]         pixel_x;
   logic [9:0]         pixel_y;
   logic               video_on;
   logic               title_px;
   logic               prompt_px;
   logic               start_btn;
   logic [COLOR_W-1:0] red;
   logic [COLOR_W-1:0] green;
   logic [COLOR_W-1:0] blue;
   logic               screen_done;

   modport master (
      output pixel_x, pixel_y, video_on, title_px, prompt_px, start_btn,
      input  red, green, blue, screen_done
   );

   modport slave (
      input  pixel_x, pixel_y, video_on, title_px, prompt_px, start_btn,
      output red, green, blue, screen_done
   );
endinterface

// File: rtl/title_screen_animator.sv
// Title-screen compositor: bouncing ball over a cup, steady title, blinking
// start prompt, then a fast-flash countdown that ends in screen_done.
module title_screen_animator #(
   parameter int COLOR_W      = 4,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BALL_X       = 575,
   parameter int BALL_TOP     = 170,
   parameter int BALL_BOTTOM  = 230,
   parameter int BALL_R2      = 225,
   parameter int BALL_STEP    = 2,
   parameter int CUP_TL       = 550,
   parameter int CUP_TR       = 600,
   parameter int CUP_BL       = 560,
   parameter int CUP_BR       = 590,
   parameter int CUP_TOP      = 250,
   parameter int CUP_BOT      = 350,
   parameter int BLINK_FRAMES = 30,
   parameter int FLASH_FRAMES = 60,
   parameter int FLASH_DIV    = 4
) (
   input logic                   clk_d,
   input logic                   rst,
   title_screen_animator_if.slave bus
);
   typedef enum logic [1:0] {TITLE, FLASH, DONE} state_t;
   typedef enum logic {DOWN, UP} dir_t;

   localparam logic [9:0]  X_LAST     = 10'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_LAST     = 10'(V_ACTIVE - 1);
   localparam logic [9:0]  B_TOP      = 10'(BALL_TOP);
   localparam logic [9:0]  B_BOT      = 10'(BALL_BOTTOM);
   localparam logic [9:0]  B_STEP     = 10'(BALL_STEP);
   localparam logic [10:0] DOWN_LIMIT = 11'(BALL_BOTTOM);
   localparam logic [10:0] UP_LIMIT   = 11'(BALL_TOP + BALL_STEP);
   localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
   localparam logic [15:0] FLASH_LAST = 16'(FLASH_FRAMES - 1);
   localparam logic [15:0] F_DIV      = 16'(FLASH_DIV);

   localparam logic signed [21:0] BX     = 22'(BALL_X);
   localparam logic signed [21:0] R2     = 22'(BALL_R2);
   localparam logic signed [21:0] C_TL   = 22'(CUP_TL);
   localparam logic signed [21:0] C_TR   = 22'(CUP_TR);
   localparam logic signed [21:0] C_BL   = 22'(CUP_BL);
   localparam logic signed [21:0] C_BR   = 22'(CUP_BR);
   localparam logic signed [21:0] C_TOP  = 22'(CUP_TOP);
   localparam logic signed [21:0] C_BOT  = 22'(CUP_BOT);
   localparam logic signed [21:0] C_SPAN = 22'(CUP_BOT - CUP_TOP);

   localparam int REP = (COLOR_W + 3) / 4;

   // MSB replication widens a nibble; taking the top bits also truncates it.
   function automatic logic [COLOR_W-1:0] scale(input logic [3:0] c);
      logic [4*REP-1:0] rep;
      rep = {REP{c}};
      return rep[4*REP-1 -: COLOR_W];
   endfunction

   localparam logic [COLOR_W-1:0] C_0 = scale(4'h0);
   localparam logic [COLOR_W-1:0] C_5 = scale(4'h5);
   localparam logic [COLOR_W-1:0] C_A = scale(4'hA);
   localparam logic [COLOR_W-1:0] C_F = scale(4'hF);

   state_t      state, state_n;
   dir_t        dir, dir_n, dir_adv;
   logic [9:0]  ball_y, ball_y_n, ball_adv;
   logic [15:0] blink_cnt, blink_cnt_n;
   logic [15:0] flash_cnt, flash_cnt_n, flash_inc;
   logic        blink_on, blink_on_n;
   logic        btn_q;
   logic        tick, start_edge, flash_even;

   logic signed [21:0] px_s, py_s, by_s, dx, dy, dist2, cup_dy, left_x, right_x;
   logic               ball_hit_c, cup_hit_c;
   logic               s1_video, s1_title, s1_prompt, s1_ball, s1_cup;

   assign tick = bus.video_on & (bus.pixel_x == X_LAST) & (bus.pixel_y == Y_LAST);
   assign start_edge = bus.start_btn & ~btn_q;
   assign flash_inc = flash_cnt + 16'd1;
   assign flash_even = ((flash_inc / F_DIV) & 16'd1) == 16'd0;
   assign bus.screen_done = (state == DONE);

   // Next ball position: one step in the current direction, clamped at the bounds.
   always_comb begin
      ball_adv = ball_y;
      dir_adv  = dir;
      if (dir == DOWN) begin
         if ({1'b0, ball_y} + {1'b0, B_STEP} >= DOWN_LIMIT) begin
            ball_adv = B_BOT;
            dir_adv  = UP;
         end else begin
            ball_adv = ball_y + B_STEP;
         end
      end else begin
         if ({1'b0, ball_y} <= UP_LIMIT) begin
            ball_adv = B_TOP;
            dir_adv  = DOWN;
         end else begin
            ball_adv = ball_y - B_STEP;
         end
      end
   end

   // Animation next-state: everything moves only on the frame tick, except the
   // start edge, which overrides the same-cycle blink update.
   always_comb begin
      state_n     = state;
      ball_y_n    = ball_y;
      dir_n       = dir;
      blink_cnt_n = blink_cnt;
      blink_on_n  = blink_on;
      flash_cnt_n = flash_cnt;
      case (state)
         TITLE: begin
            if (tick) begin
               ball_y_n = ball_adv;
               dir_n    = dir_adv;
               if (blink_cnt == BLINK_LAST) begin
                  blink_cnt_n = '0;
                  blink_on_n  = ~blink_on;
               end else begin
                  blink_cnt_n = blink_cnt + 16'd1;
               end
            end
            if (start_edge) begin
               state_n     = FLASH;
               flash_cnt_n = '0;
               blink_cnt_n = '0;
               blink_on_n  = 1'b1;
            end
         end
         FLASH: begin
            if (tick) begin
               ball_y_n = ball_adv;
               dir_n    = dir_adv;
               if (flash_cnt == FLASH_LAST) begin
                  state_n = DONE;
               end else begin
                  flash_cnt_n = flash_inc;
                  blink_on_n  = flash_even;
               end
            end
         end
         DONE: begin
         end
         default: state_n = TITLE;
      endcase
   end

   // Animation state register.
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         state     <= TITLE;
         dir       <= DOWN;
         ball_y    <= B_TOP;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
         flash_cnt <= '0;
         btn_q     <= 1'b0;
      end else begin
         state     <= state_n;
         dir       <= dir_n;
         ball_y    <= ball_y_n;
         blink_cnt <= blink_cnt_n;
         blink_on  <= blink_on_n;
         flash_cnt <= flash_cnt_n;
         btn_q     <= bus.start_btn;
      end
   end

   // Ball circle and trapezoid cup hit tests, signed so off-centre pixels work.
   always_comb begin
      px_s       = $signed({12'd0, bus.pixel_x});
      py_s       = $signed({12'd0, bus.pixel_y});
      by_s       = $signed({12'd0, ball_y});
      dx         = px_s - BX;
      dy         = py_s - by_s;
      dist2      = dx * dx + dy * dy;
      ball_hit_c = (dist2 <= R2);
      cup_dy     = py_s - C_TOP;
      left_x     = C_TL + ((C_BL - C_TL) * cup_dy) / C_SPAN;
      right_x    = C_TR + ((C_BR - C_TR) * cup_dy) / C_SPAN;
      cup_hit_c  = (py_s >= C_TOP) && (py_s <= C_BOT) && (px_s >= left_x) && (px_s <= right_x);
   end

   // Stage 1: register the pixel flags and hit results.
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         s1_video  <= 1'b0;
         s1_title  <= 1'b0;
         s1_prompt <= 1'b0;
         s1_ball   <= 1'b0;
         s1_cup    <= 1'b0;
      end else begin
         s1_video  <= bus.video_on;
         s1_title  <= bus.title_px;
         s1_prompt <= bus.prompt_px;
         s1_ball   <= ball_hit_c;
         s1_cup    <= cup_hit_c;
      end
   end

   // Stage 2: priority colour mux into the RGB output registers.
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         bus.red   <= '0;
         bus.green <= '0;
         bus.blue  <= '0;
      end else if (!s1_video || state == DONE) begin
         bus.red   <= '0;
         bus.green <= '0;
         bus.blue  <= '0;
      end else if (s1_cup) begin
         bus.red   <= C_0;
         bus.green <= C_5;
         bus.blue  <= C_F;
      end else if (s1_ball) begin
         bus.red   <= C_F;
         bus.green <= C_F;
         bus.blue  <= C_F;
      end else if (s1_title || (s1_prompt && blink_on)) begin
         bus.red   <= C_F;
         bus.green <= C_A;
         bus.blue  <= C_0;
      end else begin
         bus.red   <= C_0;
         bus.green <= C_F;
         bus.blue  <= C_F;
      end
   end
endmodule

// File: tb/tb_title_screen_animator.sv
// Directed bench for title_screen_animator: colour table plus animation sequences.
module tb_title_screen_animator;
   logic clk_d = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   mb;
   int   mdir;
   bit   ball_live;

   always #5 clk_d = ~clk_d;

   title_screen_animator_if #(.COLOR_W(4)) bus ();
   title_screen_animator #(.COLOR_W(4)) dut (.clk_d(clk_d), .rst(rst), .bus(bus));

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       vid;
      logic       title;
      logic       prompt;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int x, input int y, input bit v, input bit t, input bit p,
                               input logic [11:0] rgb, input string name);
      vec_t e;
      e.x = 10'(x); e.y = 10'(y); e.vid = v; e.title = t; e.prompt = p;
      e.r = rgb[11:8]; e.g = rgb[7:4]; e.b = rgb[3:0]; e.name = name;
      return e;
   endfunction

   task automatic cyc();
      @(posedge clk_d);
      #1;
   endtask

   task automatic set_px(input int x, input int y, input bit v, input bit t, input bit p);
      bus.pixel_x = 10'(x); bus.pixel_y = 10'(y);
      bus.video_on = v; bus.title_px = t; bus.prompt_px = p;
   endtask

   task automatic check_rgb(input string name, input logic [11:0] exp);
      checks++;
      if ({bus.red, bus.green, bus.blue} !== exp) begin
         errors++;
         $display("FAIL %s: rgb got %h expected %h", name, {bus.red, bus.green, bus.blue}, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic probe(input string name, input int x, input int y, input bit v, input bit t,
                        input bit p, input logic [11:0] exp);
      set_px(x, y, v, t, p);
      cyc();
      cyc();
      check_rgb(name, exp);
   endtask

   task automatic model_step();
      if (mdir == 0) begin
         mb += 2;
         if (mb >= 230) begin mb = 230; mdir = 1; end
      end else begin
         mb -= 2;
         if (mb <= 170) begin mb = 170; mdir = 0; end
      end
   endtask

   task automatic frame_tick();
      set_px(639, 479, 1, 0, 0);
      cyc();
      set_px(0, 0, 0, 0, 0);
      if (ball_live) model_step();
   endtask

   task automatic check_ball(input string name);
      probe({name, "_lo_in"},  575, mb + 15, 1, 0, 0, 12'hFFF);
      probe({name, "_lo_out"}, 575, mb + 16, 1, 0, 0, 12'h0FF);
      probe({name, "_hi_in"},  575, mb - 15, 1, 0, 0, 12'hFFF);
      probe({name, "_hi_out"}, 575, mb - 16, 1, 0, 0, 12'h0FF);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs.push_back(mk(575, 170, 1, 0, 0, 12'hFFF, "ball_centre"));
      vecs.push_back(mk(0,   0,   1, 0, 0, 12'h0FF, "background"));
      vecs.push_back(mk(575, 300, 1, 0, 0, 12'h05F, "cup_mid"));
      vecs.push_back(mk(575, 300, 1, 1, 1, 12'h05F, "cup_over_title"));
      vecs.push_back(mk(575, 170, 1, 1, 0, 12'hFFF, "ball_over_title"));
      vecs.push_back(mk(100, 100, 1, 1, 0, 12'hFA0, "title"));
      vecs.push_back(mk(100, 420, 1, 0, 1, 12'hFA0, "prompt_on"));
      vecs.push_back(mk(100, 100, 0, 1, 1, 12'h000, "blank_title"));
      vecs.push_back(mk(575, 170, 0, 0, 0, 12'h000, "blank_ball"));
      vecs.push_back(mk(590, 170, 1, 0, 0, 12'hFFF, "ball_r_edge"));
      vecs.push_back(mk(591, 170, 1, 0, 0, 12'h0FF, "ball_r_out"));
      vecs.push_back(mk(560, 170, 1, 0, 0, 12'hFFF, "ball_l_edge"));
      vecs.push_back(mk(559, 170, 1, 0, 0, 12'h0FF, "ball_l_out"));
      vecs.push_back(mk(584, 182, 1, 0, 0, 12'hFFF, "ball_diag_in"));
      vecs.push_back(mk(585, 182, 1, 0, 0, 12'h0FF, "ball_diag_out"));
      vecs.push_back(mk(575, 155, 1, 0, 0, 12'hFFF, "ball_top_edge"));
      vecs.push_back(mk(575, 154, 1, 0, 0, 12'h0FF, "ball_top_out"));
      vecs.push_back(mk(550, 250, 1, 0, 0, 12'h05F, "cup_tl"));
      vecs.push_back(mk(549, 250, 1, 0, 0, 12'h0FF, "cup_tl_out"));
      vecs.push_back(mk(600, 250, 1, 0, 0, 12'h05F, "cup_tr"));
      vecs.push_back(mk(601, 250, 1, 0, 0, 12'h0FF, "cup_tr_out"));
      vecs.push_back(mk(560, 350, 1, 0, 0, 12'h05F, "cup_bl"));
      vecs.push_back(mk(559, 350, 1, 0, 0, 12'h0FF, "cup_bl_out"));
      vecs.push_back(mk(590, 350, 1, 0, 0, 12'h05F, "cup_br"));
      vecs.push_back(mk(591, 350, 1, 0, 0, 12'h0FF, "cup_br_out"));
      vecs.push_back(mk(575, 249, 1, 0, 0, 12'h0FF, "cup_above"));
      vecs.push_back(mk(575, 351, 1, 0, 0, 12'h0FF, "cup_below"));
      vecs.push_back(mk(552, 275, 1, 0, 0, 12'h05F, "cup_trunc_l"));
      vecs.push_back(mk(551, 275, 1, 0, 0, 12'h0FF, "cup_trunc_l_out"));
      vecs.push_back(mk(598, 275, 1, 0, 0, 12'h05F, "cup_trunc_r"));
      vecs.push_back(mk(599, 275, 1, 0, 0, 12'h0FF, "cup_trunc_r_out"));

      rst = 1'b1;
      bus.start_btn = 1'b0;
      set_px(0, 0, 0, 0, 0);
      ball_live = 1'b1;
      mb = 170; mdir = 0;
      cyc(); cyc(); cyc();
      check_rgb("reset_rgb", 12'h000);
      check_bit("reset_done", bus.screen_done, 1'b0);
      rst = 1'b0;
      cyc();

      foreach (vecs[i])
         probe(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].vid, vecs[i].title, vecs[i].prompt,
               {vecs[i].r, vecs[i].g, vecs[i].b});

      // TITLE blink over 31 frames and ball bounce at the bottom bound.
      for (int f = 0; f <= 30; f++) begin
         probe($sformatf("title_blink_f%0d", f), 100, 420, 1, 0, 1, (f < 30) ? 12'hFA0 : 12'h0FF);
         frame_tick();
         if (f == 29) check_ball("ball_at_230");
      end
      check_ball("ball_at_228");

      // Asynchronous reset in the middle of a line.
      probe("pre_reset_title", 300, 100, 1, 1, 0, 12'hFA0);
      #2 rst = 1'b1;
      #1 check_rgb("rst_async_rgb", 12'h000);
      cyc();
      check_rgb("rst_edge_rgb", 12'h000);
      cyc();
      rst = 1'b0;
      mb = 170; mdir = 0;
      check_bit("rst_done", bus.screen_done, 1'b0);
      probe("rst_prompt_on", 100, 420, 1, 0, 1, 12'hFA0);
      check_ball("rst_ball");

      // Start edge coincident with a frame tick, then the fast flash pattern.
      for (int k = 0; k < 5; k++) frame_tick();
      set_px(639, 479, 1, 0, 0);
      bus.start_btn = 1'b1;
      cyc();
      bus.start_btn = 1'b0;
      set_px(0, 0, 0, 0, 0);
      model_step();
      for (int f = 0; f <= 8; f++) begin
         probe($sformatf("flash_f%0d", f), 100, 420, 1, 0, 1, (((f / 4) % 2) == 0) ? 12'hFA0 : 12'h0FF);
         if (f < 8) frame_tick();
      end
      check_ball("flash_ball");
      check_bit("flash_not_done", bus.screen_done, 1'b0);

      // Held start button: one FLASH entry, done after exactly 60 ticks.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      mb = 170; mdir = 0;
      bus.start_btn = 1'b1;
      cyc();
      for (int t = 1; t <= 100; t++) begin
         frame_tick();
         if (t == 60) ball_live = 1'b0;
         check_bit($sformatf("done_t%0d", t), bus.screen_done, (t >= 60) ? 1'b1 : 1'b0);
         if (t == 59) check_ball("flash_ball_t59");
      end
      probe("done_ball", 575, mb, 1, 0, 0, 12'h000);
      probe("done_prompt", 100, 420, 1, 0, 1, 12'h000);
      probe("done_title", 100, 100, 1, 1, 0, 12'h000);
      probe("done_cup", 575, 300, 1, 0, 0, 12'h000);
      probe("done_blank", 100, 100, 0, 1, 0, 12'h000);
      bus.start_btn = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
